multiword_add_seq: RTL
======================

// Module: multiword_add_seq
// PURPOSE
//  Upstream sequencer for the 32-bit carry-look-ahead adder (CLAAdder). Adds two WORDS*32-bit
//  two's-complement operands one 32-bit word per beat, least-significant word first, by
//  chaining carry across beats. Inputs and outputs use valid/ready streams. Produces one
//  registered sum word per accepted beat; the final beat also reports carry-out and signed overflow.
// PARAMETERS
//  WORDS   4   words per operand (>=1); beat counter width = max(1,$clog2(WORDS))
//  W       32  word width; fixed by CLAAdder, do not override
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   operand beat valid
//  in_ready     out  1   beat accepted when in_valid & in_ready
//  in_a         in   W   operand A word for current beat
//  in_b         in   W   operand B word for current beat
//  in_cin       in   1   carry-in; sampled on first beat only, ignored otherwise
//  out_valid    out  1   result beat valid
//  out_ready    in   1   result consumed when out_valid & out_ready
//  out_sum      out  W   sum word for the matching input beat
//  out_last     out  1   high on the beat carrying the most-significant word
//  out_carry    out  1   unsigned carry-out of MS word; valid only when out_last, else 0
//  out_overflow out  1   signed overflow of full-width add; valid only when out_last, else 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=S_IDLE, idx=0, carry reg=0, out_valid=0, out_sum=0,
//    out_last=0, out_carry=0, out_overflow=0. Reset mid-operand discards partial operand;
//    next accepted beat is treated as word 0.
//  - in_ready = !out_valid | out_ready (one-deep output register, no bubble when drained).
//    in_ready is 0 during the rst cycle.
//  - Adder inputs: a=in_a, b=in_b, cin = (state==S_IDLE) ? in_cin : carry_reg.
//  - Word carry-out is derived from CLAAdder outputs: c = (a31&b31) | ((a31^b31) & ~s31).
//  - Accepted beat -> next edge: out_sum=sum, out_valid=1, carry_reg=c,
//    out_last=(idx==WORDS-1), out_carry=last?c:0, out_overflow=last?ovf:0. Latency is 1 cycle.
//  - FSM (idx is the beat counter):
//      S_IDLE --accept, WORDS>1--> S_BUSY, idx=1
//      S_IDLE --accept, WORDS==1--> S_IDLE, idx=0
//      S_BUSY --accept, idx<WORDS-1--> S_BUSY, idx++
//      S_BUSY --accept, idx==WORDS-1--> S_IDLE, idx=0, carry_reg=0
//      No accept: state, idx and carry_reg hold.
//  - Output hold: out_valid & !out_ready -> all out_* hold stable and no beat is accepted.
//  - Simultaneous drain and accept: out_ready=1 and in_valid=1 in the same cycle ->
//    output register is reloaded and out_valid stays 1.
//  - Back-to-back operands: the first beat of the next operand may be accepted in the cycle
//    after the last beat. No dead cycle is required.
// STRUCTURE
//  - Package multiword_add_pkg holds: localparam WORD_W=32; typedef enum {S_IDLE,S_BUSY}
//    seq_state_t; function word_carry(a31,b31,s31).
//  - One sub-module: the existing CLAAdder instantiated unchanged (combinational).
//  - Sequencer FSM, beat counter, carry reg and output register are in this module.
// TESTING
//  1 WORDS=4, A=0x0..0_FFFFFFFF, B=1, cin=0, out_ready=1 -> sums 0,1,0,0;
//    out_last on beat 3 only; carry=0, ovf=0.
//  2 A=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 -> 0,0,0,0x80000000;
//    last beat carry=0, ovf=1.
//  3 A=all ones, B=0, cin=1 -> 0,0,0,0; last beat carry=1, ovf=0.
//  4 Case 1 with out_ready=0 for 3 cycles after beat 1 -> in_ready=0, out_sum=1 held
//    for all 3 cycles, then beats 2,3 = 0,0; no beat lost or duplicated.
//  5 rst=1 after 2 accepted beats, then restart case 3 -> out_valid=0 after reset;
//    in_cin honoured on restart; results match case 3.
//  6 WORDS=1, A=-999 (0xFFFFFC19), B=999 -> sum=0, last=1, carry=1, ovf=0;
//    back-to-back op 10+10 on next cycle -> 0x14.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
// Word width, FSM state encoding and per-word carry-out recovery.
package multiword_add_pkg;
  localparam int WORD_W = 32;

  typedef enum logic {S_IDLE, S_BUSY} seq_state_t;

  // The adder core exposes no carry-out; rebuild it from the operand and sum MSBs.
  function automatic logic word_carry(input logic a31, input logic b31, input logic s31);
    return (a31 & b31) | ((a31 ^ b31) & ~s31);
  endfunction
endpackage

// File: rtl/multiword_add_seq_cla.sv
// CLAAdder: 32-bit combinational carry-look-ahead adder, 4-bit lookahead groups.
// Reports the sum and the signed overflow of the word.
module CLAAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        ovf
);
  logic [31:0] w_g, w_p, w_s;
  logic [3:0]  w_gk, w_pk, w_cc;
  logic        w_c, w_c4, w_c31;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_s   = '0;
    w_gk  = '0;
    w_pk  = '0;
    w_cc  = '0;
    w_c4  = 1'b0;
    w_c31 = 1'b0;
    w_c   = cin;
    for (int k = 0; k < 8; k++) begin
      w_gk = w_g[4*k +: 4];
      w_pk = w_p[4*k +: 4];
      w_cc[0] = w_c;
      w_cc[1] = w_gk[0] | (w_pk[0] & w_c);
      w_cc[2] = w_gk[1] | (w_pk[1] & w_gk[0]) | (w_pk[1] & w_pk[0] & w_c);
      w_cc[3] = w_gk[2] | (w_pk[2] & w_gk[1]) | (w_pk[2] & w_pk[1] & w_gk[0])
              | (w_pk[2] & w_pk[1] & w_pk[0] & w_c);
      w_c4    = w_gk[3] | (w_pk[3] & w_gk[2]) | (w_pk[3] & w_pk[2] & w_gk[1])
              | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]) | ((&w_pk) & w_c);
      w_s[4*k +: 4] = w_pk ^ w_cc;
      if (k == 7) w_c31 = w_cc[3];
      w_c = w_c4;
    end
  end

  assign sum = w_s;
  assign ovf = w_c ^ w_c31;
endmodule

// File: rtl/multiword_add_seq.sv
// Streams a WORDS*32-bit add one word per beat, LS word first, chaining carry
// across beats; one-deep registered output with valid/ready on both sides.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_carry,
  output logic         out_overflow
);
  localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_out_valid, r_out_last, r_out_carry, r_out_ovf;
  logic [W-1:0]     r_out_sum, w_sum;
  logic             w_acc, w_cin, w_c, w_ovf, w_last;

  assign in_ready = !rst && (!r_out_valid || out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_cin    = (r_state == S_IDLE) ? in_cin : r_carry;
  assign w_last   = (r_idx == LAST_IDX);

  CLAAdder u_cla (
    .a   (in_a),
    .b   (in_b),
    .cin (w_cin),
    .sum (w_sum),
    .ovf (w_ovf)
  );

  assign w_c = word_carry(in_a[W-1], in_b[W-1], w_sum[W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_carry_nxt = r_carry;
    if (w_acc) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_carry_nxt = 1'b0;
      end else begin
        w_state_nxt = S_BUSY;
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_carry_nxt = w_c;
      end
    end
  end

  // Reload on accept also covers the same-cycle drain, so valid never bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_carry <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_last  <= w_last;
      r_out_carry <= w_last & w_c;
      r_out_ovf   <= w_last & w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_last     = r_out_last;
  assign out_carry    = r_out_carry;
  assign out_overflow = r_out_ovf;
endmodule
